// File: rtl/project_blastn_pkg.sv
// Shared BLASTN accelerator types: request/extension message layouts,
// seed-finder FSM states and the scan-length clamp.
package project_blastn_pkg;

  localparam int BASE_BITS = 2;
  localparam int MAX_BASES = 16;
  localparam int WORD_W    = BASE_BITS * MAX_BASES;
  localparam int FIELD_W   = 16;
  localparam int REQ_W     = 2 * WORD_W + 3 * FIELD_W;
  localparam int UGPE_W    = 2 * WORD_W + 4 * FIELD_W;

  // Declared MSB first, so query sits at bits [31:0].
  typedef struct packed {
    logic [FIELD_W-1:0] seq_len;
    logic [FIELD_W-1:0] d_start;
    logic [FIELD_W-1:0] q_start;
    logic [WORD_W-1:0]  database;
    logic [WORD_W-1:0]  query;
  } seed_req_t;

  typedef struct packed {
    logic [FIELD_W-1:0] seq_len;
    logic [FIELD_W-1:0] hit_pos;
    logic [FIELD_W-1:0] d_start;
    logic [FIELD_W-1:0] q_start;
    logic [WORD_W-1:0]  database;
    logic [WORD_W-1:0]  query;
  } ugpe_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } seed_state_e;

  // Only the first MAX_BASES bases of a word can be scanned.
  function automatic logic [4:0] eff_len(input logic [FIELD_W-1:0] seq_len);
    if (seq_len > 16'd16) begin
      return 5'd16;
    end else begin
      return seq_len[4:0];
    end
  endfunction

endpackage

// File: rtl/project_seed_finder_if.sv
// Request (istream) and extension-request (ostream) val/rdy channels of the seed finder.
interface project_seed_finder_if;
  import project_blastn_pkg::*;

  logic              istream_val;
  logic              istream_rdy;
  logic [REQ_W-1:0]  istream_msg;
  logic              ostream_val;
  logic              ostream_rdy;
  logic [UGPE_W-1:0] ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

endinterface

// File: rtl/project_seed_match_vec.sv
// Per-base match vector of two packed words and the SEED_LEN-wide
// all-match window starting at base p (bases past the word count as mismatch).
module project_seed_match_vec
  import project_blastn_pkg::*;
#(
  parameter int SEED_LEN = 4
) (
  input  logic [WORD_W-1:0]    query,
  input  logic [WORD_W-1:0]    database,
  input  logic [4:0]           p,
  output logic [MAX_BASES-1:0] eq,
  output logic                 hit
);

  logic [2*MAX_BASES-1:0] window_s;

  // Base-by-base compare, then shift so base p lands at bit 0.
  always_comb begin
    eq = '0;
    for (int i = 0; i < MAX_BASES; i++) begin
      eq[i] = (query[BASE_BITS*i +: BASE_BITS] == database[BASE_BITS*i +: BASE_BITS]);
    end
    window_s = {{MAX_BASES{1'b0}}, eq} >> p;
    hit      = &window_s[SEED_LEN-1:0];
  end

endmodule

// File: rtl/project_seed_finder.sv
// BLASTN seed hit finder: scans one base position per cycle and emits one UGPE
// extension request per SEED_LEN exact-match run. PROJECT_SEED_NONOVERLAP_EN
// makes scanning resume past the reported seed instead of at the next base.
module project_seed_finder
  import project_blastn_pkg::*;
#(
  parameter int SEED_LEN = 4
) (
  input logic                  clk,
  input logic                  reset,
  project_seed_finder_if.slave bus
);

  localparam logic [4:0] SEED_W  = 5'(SEED_LEN);
  localparam logic [4:0] MIN_LEN = 5'(SEED_LEN + 1);
`ifdef PROJECT_SEED_NONOVERLAP_EN
  localparam logic [4:0] STEP = 5'(SEED_LEN);
`else
  localparam logic [4:0] STEP = 5'd1;
`endif

  seed_state_e           state_r;
  seed_req_t             req_r;
  ugpe_req_t             out_msg_r;
  logic [4:0]            p_r;
  logic [4:0]            lim_r;
  logic                  in_rdy_r;
  logic                  out_val_r;

  seed_req_t             in_req_s;
  logic [4:0]            in_len_s;
  logic [4:0]            next_p_s;
  logic                  hit_s;
  logic [MAX_BASES-1:0]  unused_eq_s;

  assign in_req_s = bus.istream_msg;
  assign in_len_s = eff_len(in_req_s.seq_len);
  assign next_p_s = p_r + STEP;

  project_seed_match_vec #(
    .SEED_LEN (SEED_LEN)
  ) u_match (
    .query    (req_r.query),
    .database (req_r.database),
    .p        (p_r),
    .eq       (unused_eq_s),
    .hit      (hit_s)
  );

  // Control FSM; all stream outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      req_r     <= '0;
      p_r       <= 5'd0;
      lim_r     <= 5'd0;
      in_rdy_r  <= 1'b1;
      out_val_r <= 1'b0;
      out_msg_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.istream_val) begin
            req_r <= in_req_s;
            lim_r <= in_len_s - SEED_W;
            p_r   <= 5'd1;
            // Too short to hold a seed past base 0: drop the request.
            if (in_len_s >= MIN_LEN) begin
              state_r  <= ST_SCAN;
              in_rdy_r <= 1'b0;
            end else begin
              state_r  <= ST_IDLE;
              in_rdy_r <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (hit_s) begin
            state_r   <= ST_EMIT;
            out_val_r <= 1'b1;
            out_msg_r <= '{seq_len:  req_r.seq_len,
                           hit_pos:  {11'd0, p_r},
                           d_start:  req_r.d_start,
                           q_start:  req_r.q_start,
                           database: req_r.database,
                           query:    req_r.query};
          end else if (p_r == lim_r) begin
            state_r  <= ST_IDLE;
            in_rdy_r <= 1'b1;
          end else begin
            p_r <= p_r + 5'd1;
          end
        end
        ST_EMIT: begin
          if (bus.ostream_rdy) begin
            out_val_r <= 1'b0;
            out_msg_r <= '0;
            p_r       <= next_p_s;
            if (next_p_s > lim_r) begin
              state_r  <= ST_IDLE;
              in_rdy_r <= 1'b1;
            end else begin
              state_r <= ST_SCAN;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_rdy_r  <= 1'b1;
          out_val_r <= 1'b0;
          out_msg_r <= '0;
        end
      endcase
    end
  end

  assign bus.istream_rdy = in_rdy_r;
  assign bus.ostream_val = out_val_r;
  assign bus.ostream_msg = out_msg_r;

endmodule

// File: tb/tb_project_seed_finder.sv
// Scoreboard bench for project_seed_finder: expected UGPE messages are queued
// from a reference scan at request time and popped on each output handshake.
module tb_project_seed_finder;
  import project_blastn_pkg::*;

  localparam int SL = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [127:0] sb_q[$];

  project_seed_finder_if bus_if ();

  project_seed_finder #(.SEED_LEN(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference scan straight from the operation description.
  task automatic push_expected(input logic [31:0] q, input logic [31:0] d,
                               input logic [15:0] qs, input logic [15:0] ds,
                               input logic [15:0] len);
    int L;
    int p;
    int step;
    bit all_eq;
    L = (len > 16'd16) ? 16 : int'(len);
`ifdef PROJECT_SEED_NONOVERLAP_EN
    step = SL;
`else
    step = 1;
`endif
    p = 1;
    while (L >= SL + 1 && p <= L - SL) begin
      all_eq = 1'b1;
      for (int k = p; k < p + SL; k++) begin
        if (q[2*k +: 2] != d[2*k +: 2]) all_eq = 1'b0;
      end
      if (all_eq) begin
        sb_q.push_back({len, 16'(p), ds, qs, d, q});
        p = p + step;
      end else begin
        p = p + 1;
      end
    end
  endtask

  // Drives one request; returns just after the accepting edge (cycle 0).
  task automatic send_req(input logic [31:0] q, input logic [31:0] d,
                          input logic [15:0] qs, input logic [15:0] ds,
                          input logic [15:0] len);
    push_expected(q, d, qs, ds, len);
    @(posedge clk);
    #1;
    bus_if.istream_msg = {len, ds, qs, d, q};
    bus_if.istream_val = 1'b1;
    @(posedge clk);
    #1;
    bus_if.istream_val = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus_if.istream_rdy && sb_q.size() == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 128'(n < 400), 128'd1);
  endtask

  // Scoreboard consumer: every transferred message must be the next expected one.
  always @(negedge clk) begin
    if (!reset && bus_if.ostream_val && bus_if.ostream_rdy) begin
      if (sb_q.size() == 0) begin
        check_val("sb_extra", bus_if.ostream_msg, 128'd0);
        check_val("sb_extra_val", 128'd1, 128'd0);
      end else begin
        check_val("sb_msg", bus_if.ostream_msg, sb_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset              = 1'b1;
    bus_if.istream_val = 1'b0;
    bus_if.istream_msg = '0;
    bus_if.ostream_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_rdy", 128'(bus_if.istream_rdy), 128'd1);
    check_val("rst_val", 128'(bus_if.ostream_val), 128'd0);
    check_val("rst_msg", bus_if.ostream_msg, 128'd0);

    // Identical words: every position (or every non-overlapping one) hits.
    send_req(32'h12345678, 32'h12345678, 16'h0001, 16'h0002, 16'd16);
    wait_idle("same16_done");

    // Single seed at base 4, first output at cycle 5.
    send_req(32'h00000000, 32'hFFFF00FF, 16'h0020, 16'h0040, 16'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.ostream_val && n < 50);
    check_val("hit4_cycle", 128'(n), 128'd5);
    check_val("hit4_msg", bus_if.ostream_msg,
              {16'd16, 16'd4, 16'h0040, 16'h0020, 32'hFFFF00FF, 32'h0});
    wait_idle("hit4_done");

    // No hits: ready again at cycle L-SEED_LEN+1.
    send_req(32'h00000000, 32'hFFFFFFFF, 16'h0000, 16'h0000, 16'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.istream_rdy && n < 50);
    check_val("nohit_rdy_cycle", 128'(n), 128'd13);

    // seq_len equal to SEED_LEN: no positions, back to IDLE immediately.
    send_req(32'hAAAAAAAA, 32'hAAAAAAAA, 16'h0000, 16'h0000, 16'd4);
    @(negedge clk);
    check_val("short_rdy", 128'(bus_if.istream_rdy), 128'd1);
    check_val("short_val", 128'(bus_if.ostream_val), 128'd0);

    // Over-long seq_len: scan clamps at 16, field keeps 20.
    send_req(32'h9C3E71B4, 32'h9C3E71B4, 16'h0100, 16'h0200, 16'd20);
    wait_idle("len20_done");

    // Mixed pattern with partial matches.
    send_req(32'h0F0F_5A5A, 32'h0F1F_5A5B, 16'h0003, 16'h0004, 16'd14);
    wait_idle("mixed_done");

    // Backpressure: message must hold for 5 stalled cycles.
    bus_if.ostream_rdy = 1'b0;
    send_req(32'h12345678, 32'h12345678, 16'h0011, 16'h0022, 16'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.ostream_val && n < 50);
    check_val("bp_val_seen", 128'(bus_if.ostream_val), 128'd1);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_hold_val", 128'(bus_if.ostream_val), 128'd1);
      check_val("bp_hold_msg", bus_if.ostream_msg, (sb_q.size() > 0) ? sb_q[0] : 128'd0);
      @(negedge clk);
    end
    bus_if.ostream_rdy = 1'b1;
    wait_idle("bp_done");

    // Reset while holding a message in EMIT.
    bus_if.ostream_rdy = 1'b0;
    send_req(32'h12345678, 32'h12345678, 16'h0005, 16'h0006, 16'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.ostream_val && n < 50);
    check_val("rstemit_val_seen", 128'(bus_if.ostream_val), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rstemit_val", 128'(bus_if.ostream_val), 128'd0);
    check_val("rstemit_rdy", 128'(bus_if.istream_rdy), 128'd1);
    check_val("rstemit_msg", bus_if.ostream_msg, 128'd0);
    sb_q.delete();
    bus_if.ostream_rdy = 1'b1;

    send_req(32'h00000000, 32'hFFFF00FF, 16'h0020, 16'h0040, 16'd16);
    wait_idle("after_rst_done");
    check_val("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/project_seed_finder.md
# project_seed_finder

Seed (k-mer) hit finder for the BLASTN accelerator; sits directly upstream of the ungapped-extension engine (UGPE). It accepts one packed query/database word pair, scans diagonal-aligned base positions one per cycle for runs of `SEED_LEN` exact matches, and emits one 128-bit extension request per hit in the exact message format the UGPE consumes.

## Interface
- `SEED_LEN`, default 4: seed length in bases; legal range 1..15.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `istream_val`  in  1  request valid.
- `istream_rdy`  out  1  block can accept a request; high only in IDLE.
- `istream_msg`  in  112  fields:
  - [31:0] query, 16 bases × 2 bits; base i at bits [2i+1:2i].
  - [63:32] database, same packing.
  - [79:64] q_start.
  - [95:80] d_start.
  - [111:96] seq_len.
- `ostream_val`  out  1  hit message valid.
- `ostream_rdy`  in  1  downstream (UGPE) accepts.
- `ostream_msg`  out  128  fields:
  - [31:0] query, [63:32] database.
  - [79:64] q_start, [95:80] d_start (passed through unchanged).
  - [111:96] hit_pos.
  - [127:112] seq_len as received.
  - All zero whenever `ostream_val`=0.

## Operation
- Effective length `L = min(seq_len, 16)`. Scanned positions are `p = 1 .. L-SEED_LEN`; `p=0` is never reported, because the UGPE right extension needs `hit_pos ≥ 1`.
- If `L < SEED_LEN+1`, there are no positions; the request produces no output.
- Match vector: `eq[i] = (q base i == d base i)`, taken from the registered words. A hit at `p` means `eq[p..p+SEED_LEN-1]` are all 1.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - Outputs: `istream_rdy=1`, `ostream_val=0`.
  - On `istream_val`, register all fields, set `p=1`, go to SCAN.
  - If no positions exist, go straight back to IDLE instead.
- SCAN, one position per cycle:
  - Hit at `p`: latch `hit_pos=p`, go to EMIT.
  - No hit and `p == L-SEED_LEN`: go to IDLE.
  - Otherwise: `p++`.
- EMIT:
  - `ostream_val=1`; the message is held stable until `ostream_rdy`.
  - On the cycle `ostream_rdy` is sampled high, advance `p` (see Configuration).
  - If the new `p > L-SEED_LEN`, go to IDLE; otherwise go to SCAN.
- Counters: `p` is 5 bits. The comparison against `L-SEED_LEN` is unsigned and only evaluated when `L ≥ SEED_LEN+1`, so the subtraction cannot underflow.
- `seq_len > 16`: scanning is clamped to 16, and the emitted `seq_len` field is the original value.
- New requests are never accepted while a request is in flight. There is no input buffering.

## Timing
- Reset: state IDLE, `p=0`, all data registers zero. In the first cycle after reset, `ostream_val=0`, `ostream_msg=0` and `istream_rdy=1`.
- Reset asserted in any state (including EMIT with `ostream_val` high) abandons the request. The outputs take their reset values in the next cycle.
- Handshake is val/rdy; a transfer occurs when both are high on a rising edge. `ostream_val` does not depend combinationally on `ostream_rdy`.
- Latency: request accepted at cycle 0. SCAN visits `p` at cycle `p` (for the first hit). A hit at `p` raises `ostream_val` at cycle `p+1`.
- After an EMIT handshake, SCAN resumes at the next position in the following cycle.
- Request with no hits: `istream_rdy` rises again at cycle `L-SEED_LEN+1`.

## Configuration
- `PROJECT_SEED_NONOVERLAP_EN`:
  - Defined: after an emitted hit at `p`, scanning resumes at `p+SEED_LEN`, so reported seeds never overlap.
  - Undefined: scanning resumes at `p+1`, so every matching position is reported.

## Structure
- Shared package `project_blastn_pkg`:
  - Constants: `BASE_BITS=2`, `MAX_BASES=16`.
  - Input and output message field offsets/widths, typedef'd as packed structs `seed_req_t` and `ugpe_req_t`.
  - FSM state enum `seed_state_e`.
- One sub-module: `project_seed_match_vec`, combinational. It takes query and database words and produces the 16-bit `eq` vector plus a `SEED_LEN`-window AND indexed by `p`.

## Test plan
- Query = database = 0x12345678, seq_len=16, `SEED_LEN`=4:
  - Without the macro: 12 messages with hit_pos 1..12, in order.
  - With `PROJECT_SEED_NONOVERLAP_EN`: hit_pos 1, 5, 9 only.
- query=0x00000000, database=0xFFFF00FF, seq_len=16, q_start=0x20, d_start=0x40 → one message at cycle 5: hit_pos=4, and `ostream_msg` = {16'd16, 16'd4, 16'h0040, 16'h0020, 32'hFFFF00FF, 32'h0}.
- query=0x00000000, database=0xFFFFFFFF, seq_len=16 → no output; `istream_rdy` high again at cycle 13.
- seq_len=4 → no output, IDLE the next cycle. seq_len=20 with identical words → hits 1..12, emitted seq_len field = 20.
- Backpressure: hold `ostream_rdy`=0 for 5 cycles during EMIT → `ostream_msg` stable and `p` frozen; no message is lost or duplicated.
- Assert reset during EMIT → next cycle `ostream_val`=0 and `istream_rdy`=1; a fresh request then behaves normally.
